mips_multicycle_ctrl: RTL and testbench

- Moore/Mealy FSM that sequences the shared multicycle MIPS datapath (PC, IR, register file, ALU, unified memory) over 3–5 cycles per instruction.
- Replaces the single-cycle opcode decoder for the multicycle core.
- Adds a memory ready handshake, a memory timeout, and a retired-instruction counter.
- Sits between the IR opcode field and all datapath mux selects and write enables.

---
 rtl/mips_multicycle_ctrl.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences PC/IR/regfile/ALU/memory over 3-5 cycles per instruction,
// with mem_ready wait states, a memory timeout into HALT, and a retired-instruction counter.
// Optional feature macro: ILLEGAL_TRAP_EN (undefined opcode traps to HALT instead of acting as a NOP).
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [4:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             mem_err,
    output logic             trap
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SEQ   = 6'b011000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [5:0]         opc_q, opc_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               mem_err_q, mem_err_d;
    logic               waiting;
    logic               timeout;
    logic               decode_legal;
    logic               done;

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI,
            OP_XORI, OP_SLTI, OP_SEQ, OP_BEQ, OP_J: is_legal = 1'b1;
            default:                                is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ADDI: imm_alu_op = 5'b00011;
            OP_ANDI: imm_alu_op = 5'b00100;
            OP_ORI:  imm_alu_op = 5'b00101;
            OP_XORI: imm_alu_op = 5'b00110;
            OP_SLTI: imm_alu_op = 5'b00111;
            OP_SEQ:  imm_alu_op = 5'b01000;
            default: imm_alu_op = 5'b00000;
        endcase
    endfunction

    assign waiting      = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // mem_ready takes priority over a timeout landing in the same cycle
    assign timeout      = waiting && !mem_ready && (wait_q == WAIT_LAST);
    assign decode_legal = is_legal(opcode);

`ifdef ILLEGAL_TRAP_EN
    logic trap_q, trap_d;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            opc_q     <= 6'b000000;
            wait_q    <= '0;
            retired_q <= '0;
            mem_err_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            trap_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            mem_err_q <= mem_err_d;
`ifdef ILLEGAL_TRAP_EN
            trap_q    <= trap_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        mem_err_d = mem_err_q;
`ifdef ILLEGAL_TRAP_EN
        trap_d    = trap_q;
`endif
        case (state_q)
            S_FETCH: begin
                if (mem_ready)    state_d = S_DECODE;
                else if (timeout) state_d = S_HALT;
            end
            S_DECODE: begin
                opc_d = opcode;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SEQ:
                                  state_d = S_I_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        trap_d  = 1'b1;
                        state_d = S_HALT;
`else
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (opc_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready)    state_d = S_MEM_WB;
                else if (timeout) state_d = S_HALT;
            end
            S_MEM_WB: state_d = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready)    state_d = S_FETCH;
                else if (timeout) state_d = S_HALT;
            end
            S_R_EXEC: state_d = S_R_WB;
            S_R_WB:   state_d = S_FETCH;
            S_I_EXEC: state_d = S_I_WB;
            S_I_WB:   state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase

        if (timeout) mem_err_d = 1'b1;

        // Any state change (including into HALT) restarts the wait count
        if (waiting && !mem_ready && (state_d == state_q)) wait_d = wait_q + 1'b1;
        else                                               wait_d = '0;

        retired_d = retired_q + CNT_W'(done);
    end

    // Output logic
    always_comb begin
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 5'b00000;
        pc_source  = 2'b00;
        done       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
`ifndef ILLEGAL_TRAP_EN
                done      = !decode_legal;
`endif
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                done       = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                done      = mem_ready;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 5'b00010;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                alu_op    = 5'b00010;
                done      = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = imm_alu_op(opc_q);
            end
            S_I_WB: begin
                reg_write = 1'b1;
                alu_op    = imm_alu_op(opc_q);
                done      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 5'b00001;
                pc_source = 2'b01;
                pc_write  = zero;
                done      = 1'b1;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase

        // Reset puts the FSM in FETCH, whose read request must not leak out while held
        if (!rst_n) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            done      = 1'b0;
        end
    end

    assign instr_done = done;
    assign retired    = retired_q;
    assign mem_err    = mem_err_q;

`ifdef ILLEGAL_TRAP_EN
    assign trap = trap_q;
`else
    logic unused_legal;
    assign unused_legal = decode_legal;
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: every cycle's control vector is compared with a
// hand-written constant; inputs change 1ns after the rising edge and outputs are sampled 1ns later.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'b000000;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic        alu_src_a, instr_done, mem_err, trap;
    logic [1:0]  alu_src_b, pc_source;
    logic [4:0]  alu_op;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .instr_done(instr_done), .retired(retired), .mem_err(mem_err), .trap(trap)
    );

    always #5 clk = ~clk;

    logic [18:0] ctl;
    assign ctl = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, alu_op, pc_source, instr_done};

    logic [5:0] enables;
    assign enables = {pc_write, ir_write, reg_write, mem_read, mem_write, instr_done};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, ORI = 6'b001101;
    localparam logic [5:0] XORI = 6'b001110, SEQ = 6'b011000, BEQ = 6'b000100, JMP = 6'b000010;
    localparam logic [5:0] BADOP = 6'b111111;

    function automatic logic [18:0] mk(input logic pw, input logic io, input logic mr,
                                       input logic mw, input logic irw, input logic rd,
                                       input logic m2r, input logic rw, input logic asa,
                                       input logic [1:0] asb, input logic [4:0] aop,
                                       input logic [1:0] pcs, input logic dn);
        return {pw, io, mr, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, dn};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, compare the control vector, then advance past the next edge.
    task automatic cyc(input string tag, input logic [5:0] op, input logic rdy, input logic z,
                       input logic [18:0] exp);
        opcode = op; mem_ready = rdy; zero = z;
        #1;
        chk(tag, 32'(ctl), 32'(exp));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mem_ready = 1'b0;
        #1;
        chk("rst_enables", 32'(enables), 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    logic [18:0] F0, F1, DEC, DECNOP, MA, MRD, MWB, MWR, MWRD, REX, RWB, BRT, BRF, JP, HLT;

    initial begin
        F0     = mk(0,0,1,0,0,0,0,0,0,2'b01,5'b00000,2'b00,0);
        F1     = mk(1,0,1,0,1,0,0,0,0,2'b01,5'b00000,2'b00,0);
        DEC    = mk(0,0,0,0,0,0,0,0,0,2'b11,5'b00000,2'b00,0);
        DECNOP = mk(0,0,0,0,0,0,0,0,0,2'b11,5'b00000,2'b00,1);
        MA     = mk(0,0,0,0,0,0,0,0,1,2'b10,5'b00000,2'b00,0);
        MRD    = mk(0,1,1,0,0,0,0,0,0,2'b00,5'b00000,2'b00,0);
        MWB    = mk(0,0,0,0,0,0,1,1,0,2'b00,5'b00000,2'b00,1);
        MWR    = mk(0,1,0,1,0,0,0,0,0,2'b00,5'b00000,2'b00,0);
        MWRD   = mk(0,1,0,1,0,0,0,0,0,2'b00,5'b00000,2'b00,1);
        REX    = mk(0,0,0,0,0,0,0,0,1,2'b00,5'b00010,2'b00,0);
        RWB    = mk(0,0,0,0,0,1,0,1,0,2'b00,5'b00010,2'b00,1);
        BRT    = mk(1,0,0,0,0,0,0,0,1,2'b00,5'b00001,2'b01,1);
        BRF    = mk(0,0,0,0,0,0,0,0,1,2'b00,5'b00001,2'b01,1);
        JP     = mk(1,0,0,0,0,0,0,0,0,2'b00,5'b00000,2'b10,1);
        HLT    = 19'd0;

        do_reset();

        // lw, one wait cycle in FETCH and in MEM_RD: 7 cycles; IR changes after DECODE ignored
        cyc("lw_f_wait", LW, 0, 0, F0);
        cyc("lw_f_rdy",  LW, 1, 0, F1);
        cyc("lw_dec",    LW, 0, 0, DEC);
        cyc("lw_addr",   RT, 0, 0, MA);
        cyc("lw_rd_wait", RT, 0, 0, MRD);
        cyc("lw_rd_rdy", RT, 1, 0, MRD);
        cyc("lw_wb",     RT, 0, 0, MWB);
        chk("lw_retired", retired, 32'd1);

        // beq taken then not taken
        cyc("beq1_f",   BEQ, 1, 0, F1);
        cyc("beq1_dec", BEQ, 0, 0, DEC);
        cyc("beq1_br",  BEQ, 0, 1, BRT);
        cyc("beq2_f",   BEQ, 1, 0, F1);
        cyc("beq2_dec", BEQ, 0, 0, DEC);
        cyc("beq2_br",  BEQ, 0, 0, BRF);
        chk("beq_retired", retired, 32'd3);

        // R-type, ori, xori, seq back to back
        cyc("r_f",    RT, 1, 0, F1);
        cyc("r_dec",  RT, 0, 0, DEC);
        cyc("r_exec", RT, 0, 0, REX);
        cyc("r_wb",   RT, 0, 0, RWB);
        cyc("ori_f",    ORI, 1, 0, F1);
        cyc("ori_dec",  ORI, 0, 0, DEC);
        cyc("ori_exec", ORI, 0, 0, mk(0,0,0,0,0,0,0,0,1,2'b10,5'b00101,2'b00,0));
        cyc("ori_wb",   ORI, 0, 0, mk(0,0,0,0,0,0,0,1,0,2'b00,5'b00101,2'b00,1));
        cyc("xori_f",    XORI, 1, 0, F1);
        cyc("xori_dec",  XORI, 0, 0, DEC);
        cyc("xori_exec", XORI, 0, 0, mk(0,0,0,0,0,0,0,0,1,2'b10,5'b00110,2'b00,0));
        cyc("xori_wb",   XORI, 0, 0, mk(0,0,0,0,0,0,0,1,0,2'b00,5'b00110,2'b00,1));
        cyc("seq_f",    SEQ, 1, 0, F1);
        cyc("seq_dec",  SEQ, 0, 0, DEC);
        cyc("seq_exec", RT,  0, 0, mk(0,0,0,0,0,0,0,0,1,2'b10,5'b01000,2'b00,0));
        cyc("seq_wb",   RT,  0, 0, mk(0,0,0,0,0,0,0,1,0,2'b00,5'b01000,2'b00,1));
        chk("alu_retired", retired, 32'd7);

        // sw with immediate ready, then j
        cyc("sw_f",    SW, 1, 0, F1);
        cyc("sw_dec",  SW, 0, 0, DEC);
        cyc("sw_addr", SW, 0, 0, MA);
        cyc("sw_wr",   SW, 1, 0, MWRD);
        cyc("j_f",   JMP, 1, 0, F1);
        cyc("j_dec", JMP, 0, 0, DEC);
        cyc("j_jmp", JMP, 0, 0, JP);
        chk("j_retired", retired, 32'd9);

        // sw where mem_ready lands on the 16th wait cycle: transfer completes
        cyc("swe_f",    SW, 1, 0, F1);
        cyc("swe_dec",  SW, 0, 0, DEC);
        cyc("swe_addr", SW, 0, 0, MA);
        for (int i = 0; i < 15; i++) cyc("swe_wait", SW, 0, 0, MWR);
        cyc("swe_rdy16", SW, 1, 0, MWRD);
        chk("swe_mem_err", 32'(mem_err), 32'd0);
        chk("swe_retired", retired, 32'd10);

        // undefined opcode
        cyc("bad_f", BADOP, 1, 0, F1);
`ifdef ILLEGAL_TRAP_EN
        cyc("bad_dec",  BADOP, 0, 0, DEC);
        cyc("bad_halt", BADOP, 1, 0, HLT);
        chk("bad_trap", 32'(trap), 32'd1);
        chk("bad_retired", retired, 32'd10);
`else
        cyc("bad_dec",   BADOP, 0, 0, DECNOP);
        cyc("bad_fetch", BADOP, 0, 0, F0);
        chk("bad_trap", 32'(trap), 32'd0);
        chk("bad_retired", retired, 32'd11);
`endif
        do_reset();

        // sw timeout: 16 MEM_WR cycles without mem_ready -> mem_err, HALT until reset
        cyc("swt_f",    SW, 1, 0, F1);
        cyc("swt_dec",  SW, 0, 0, DEC);
        cyc("swt_addr", SW, 0, 0, MA);
        for (int i = 0; i < 16; i++) begin
            chk("swt_err_low", 32'(mem_err), 32'd0);
            cyc("swt_wait", SW, 0, 0, MWR);
        end
        chk("swt_mem_err", 32'(mem_err), 32'd1);
        for (int i = 0; i < 3; i++) cyc("swt_halt", SW, 1, 0, HLT);
        chk("swt_err_sticky", 32'(mem_err), 32'd1);
        chk("swt_retired", retired, 32'd0);
        do_reset();
        cyc("swt_after_rst", RT, 0, 0, F0);

        // asynchronous reset in the middle of MEM_RD
        cyc("ar_j_f",   JMP, 1, 0, F1);
        cyc("ar_j_dec", JMP, 0, 0, DEC);
        cyc("ar_j_jmp", JMP, 0, 0, JP);
        chk("ar_retired_pre", retired, 32'd1);
        cyc("ar_lw_f",    LW, 1, 0, F1);
        cyc("ar_lw_dec",  LW, 0, 0, DEC);
        cyc("ar_lw_addr", LW, 0, 0, MA);
        mem_ready = 1'b0;
        #1;
        chk("ar_mem_rd", 32'(ctl), 32'(MRD));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_enables", 32'(enables), 32'd0);
        chk("ar_retired", retired, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc("ar_fetch", LW, 0, 0, F0);
        chk("ar_retired_post", retired, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
